// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART core.
// The rx_we pulse from the baud-clock domain is synchronised. Each rising edge
// of that pulse pushes one byte into a DEPTH-entry circular FIFO. The consumer
// side is first-word-fall-through: rd_data always shows the head byte. The
// block reports full, empty and count, plus sticky overflow and underflow flags.
module uart_rx_fifo #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       rx_we,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Synchroniser chain for rx_we. fill_r tracks how far the chain has been
    // refilled with real samples since reset. The zeros loaded by reset are
    // not a genuine observation of rx_we being low. Without this tracking, a
    // write-enable held high through reset release would arm the capture
    // logic and cause a spurious push.
    logic [SYNC_STAGES-1:0] sync_r;
    logic [SYNC_STAGES-1:0] fill_r;
    logic                   prev_r;
    logic                   armed_r;

    logic                   sync_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   wr_ok_s;
    logic                   ovf_set_s;
    logic                   udf_set_s;
    logic [CNT_W-1:0]       count_nxt_s;

    logic [DATA_W-1:0]      mem_r [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic                   empty_r;
    logic                   full_r;
    logic                   overflow_r;
    logic                   underflow_r;

    // Synchronise rx_we, remember the previous level and arm on the first genuine low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r  <= '0;
            fill_r  <= '0;
            prev_r  <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], rx_we};
            fill_r  <= {fill_r[SYNC_STAGES-2:0], 1'b1};
            prev_r  <= sync_s;
            armed_r <= armed_r | (fill_r[SYNC_STAGES-1] & ~sync_s);
        end
    end

    // Derive push/pop, error set conditions and the next occupancy.
    always_comb begin
        sync_s      = sync_r[SYNC_STAGES-1];
        push_s      = armed_r & sync_s & ~prev_r;
        pop_s       = rd_en & ~empty_r;
        // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
        wr_ok_s     = push_s & (~full_r | pop_s);
        ovf_set_s   = push_s & full_r & ~pop_s;
        udf_set_s   = rd_en & empty_r;
        count_nxt_s = count_r;
        case ({wr_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array write; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= rx_data;
        end
    end

    // Pointers, registered occupancy flags and sticky error flags (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            empty_r     <= 1'b1;
            full_r      <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r     <= count_nxt_s;
            empty_r     <= (count_nxt_s == '0);
            full_r      <= (count_nxt_s == DEPTH_C);
            overflow_r  <= (overflow_r & ~clr_err) | ovf_set_s;
            underflow_r <= (underflow_r & ~clr_err) | udf_set_s;
        end
    end

    // First-word-fall-through read data, forced to zero while empty.
    always_comb begin
        if (empty_r) begin
            rd_data = '0;
        end else begin
            rd_data = mem_r[rd_ptr_r];
        end
    end

    assign empty     = empty_r;
    assign full      = full_r;
    assign count     = count_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule
